// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: ALU operation
// codes, FSM state encoding, iteration mode and small decode helpers.
package hilo_muldiv_ctrl_pkg;

    // ALU operation encodings (4-bit alu_op field)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd10;
    localparam logic [3:0] ALU_DIV = 4'd11;
    localparam logic [3:0] ALU_HIR = 4'd12;  // MFHI
    localparam logic [3:0] ALU_LOR = 4'd13;  // MFLO
    localparam logic [3:0] ALU_HIW = 4'd14;  // MTHI
    localparam logic [3:0] ALU_LOW = 4'd15;  // MTLO

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // True for operations that launch a multi-cycle sequence
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    // True for operations that read or write HI/LO directly
    function automatic logic is_hilo(input logic [3:0] op);
        return (op == ALU_HIR) || (op == ALU_LOR) ||
               (op == ALU_HIW) || (op == ALU_LOW);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH
// accumulator. Purely combinational; the controller registers acc_next.
module hilo_muldiv_ctrl_iter
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_t              mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_rem_sh;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    // Multiply: conditional add into the upper half, then shift right.
    // Divide: shift {rem,quo} left, trial-subtract; the borrow bit of the
    // (WIDTH+1)-bit difference says whether the subtraction is kept.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, operand};
        div_ge     = ~div_diff[WIDTH];
        if (mode == MODE_MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with the architectural HI/LO
// registers. Operands are reduced to magnitudes at start, iterated one bit
// per cycle, and sign-corrected in a final FIX cycle that writes HI/LO.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    input  logic [3:0]       alu_op,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] alusrc_1,
    input  logic [WIDTH-1:0] alusrc_2,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               start;
    logic               fix_wr;

    logic               src1_neg, src2_neg;
    logic [WIDTH-1:0]   mag1, mag2;

    mode_t              mode;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   dvd_orig;
    logic               sgn_q, sgn_r, div0;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operand magnitudes; for unsigned ops the operands pass through as-is.
    // The most negative value maps onto itself, which is the right unsigned
    // magnitude for the iteration.
    always_comb begin
        src1_neg = signed_i & alusrc_1[WIDTH-1];
        src2_neg = signed_i & alusrc_2[WIDTH-1];
        mag1     = src1_neg ? -alusrc_1 : alusrc_1;
        mag2     = src2_neg ? -alusrc_2 : alusrc_2;
    end

    hilo_muldiv_ctrl_iter #(
        .WIDTH    (WIDTH)
    ) u_iter (
        .mode     (mode),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_step)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, start/write strobes and the hazard-unit stall
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fix_wr    = 1'b0;
        done_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid_i && is_muldiv(alu_op) && !flush_i) begin
                    start     = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                if (!flush_i) begin
                    fix_wr = 1'b1;
                    done_o = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // HI/LO accesses while busy are held by the general busy term; the
        // explicit term documents that they must wait for the result.
        stall_o = (state != ST_IDLE) | start |
                  (op_valid_i & is_hilo(alu_op) & (state != ST_IDLE));
    end

    // Iteration counter: cleared on start, advanced once per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand latch at start and accumulator update during BUSY
    always_ff @(posedge clk) begin
        if (start) begin
            if (alu_op == ALU_DIV) begin
                mode <= MODE_DIV;
                acc  <= {{WIDTH{1'b0}}, mag1};
                opnd <= mag2;
            end else begin
                mode <= MODE_MUL;
                acc  <= {{WIDTH{1'b0}}, mag2};
                opnd <= mag1;
            end
            sgn_q    <= src1_neg ^ src2_neg;
            sgn_r    <= src1_neg;
            div0     <= (alusrc_2 == '0);
            dvd_orig <= alusrc_1;
        end else if (state == ST_BUSY) begin
            acc <= acc_step;
        end
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        prod = sgn_q ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (mode == MODE_MUL) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div0) begin
            fix_hi = dvd_orig;
            fix_lo = '1;
        end else begin
            fix_hi = sgn_r ? -rem : rem;
            fix_lo = sgn_q ? -quo : quo;
        end
    end

    // HI/LO registers: result write from FIX, or MTHI/MTLO while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_wr) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if ((state == ST_IDLE) && op_valid_i && !flush_i) begin
            if (alu_op == ALU_HIW) begin
                hi_q <= alusrc_1;
            end
            if (alu_op == ALU_LOW) begin
                lo_q <= alusrc_1;
            end
        end
    end

    // MFHI/MFLO read mux straight from the registers
    always_comb begin
        hilo_out = '0;
        if (alu_op == ALU_HIR) begin
            hilo_out = hi_q;
        end else if (alu_op == ALU_LOR) begin
            hilo_out = lo_q;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus randomized
// multiply/divide checked against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid_i;
    logic [3:0]  alu_op;
    logic        signed_i;
    logic [31:0] alusrc_1;
    logic [31:0] alusrc_2;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hilo_out;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_ctrl #(
        .WIDTH      (32),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid_i (op_valid_i),
        .alu_op     (alu_op),
        .signed_i   (signed_i),
        .alusrc_1   (alusrc_1),
        .alusrc_2   (alusrc_2),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .hilo_out   (hilo_out),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_model(input bit is_div, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        logic [31:0] q, m;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (!is_div) begin
            r = 64'(sa * sb);
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            q = 32'(sa / sb);
            m = 32'(sa % sb);
            r = {m, q};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one mul/div at cycle t and check stall length, done timing and result
    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input string tag);
        int nst, nd, dk;
        nst = 0; nd = 0; dk = -1;
        op_valid_i = 1'b1; alu_op = op; signed_i = sgn; alusrc_1 = a; alusrc_2 = b;
        for (int k = 0; k < 34; k++) begin
            #1;
            if (stall_o === 1'b1) nst++;
            if (done_o === 1'b1) begin nd++; dk = k; end
            tick();
            op_valid_i = 1'b0; alu_op = ALU_ADD;
            alusrc_1 = $urandom; alusrc_2 = $urandom;
        end
        #1;
        chk({tag, ".stall_len"}, 32'(nst), 32'd34);
        chk({tag, ".done"}, 32'(nd * 256 + dk), 32'(256 + 33));
        chk({tag, ".stall_end"}, {31'd0, stall_o}, 32'd0);
        chk({tag, ".hi"}, hi_o, exp[63:32]);
        chk({tag, ".lo"}, lo_o, exp[31:0]);
    endtask

    // MTHI/MTLO in one cycle, checking that it never stalls
    task automatic mt(input logic [3:0] op, input logic [31:0] d, input string tag);
        op_valid_i = 1'b1; alu_op = op; alusrc_1 = d;
        #1;
        chk({tag, ".nostall"}, {31'd0, stall_o}, 32'd0);
        tick();
        op_valid_i = 1'b0; alu_op = ALU_ADD;
    endtask

    initial begin
        int n, nd;
        bit isdiv, sgn;
        logic [31:0] a, b;
        rst_n = 1'b0; op_valid_i = 1'b0; alu_op = ALU_ADD; signed_i = 1'b0;
        alusrc_1 = '0; alusrc_2 = '0; flush_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", {31'd0, stall_o}, 32'd0);
        chk("rst.done", {31'd0, done_o}, 32'd0);
        chk("rst.hi", hi_o, 32'd0);
        chk("rst.lo", lo_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op(ALU_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(ALU_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mult_m3x5");
        run_op(ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7d2");
        run_op(ALU_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7dm2");
        run_op(ALU_DIV, 1'b0, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, "divu_by0");
        run_op(ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");

        // MTHI/MTLO then MFHI/MFLO
        mt(ALU_HIW, 32'h1234_5678, "mthi");
        mt(ALU_LOW, 32'h9ABC_DEF0, "mtlo");
        op_valid_i = 1'b1; alu_op = ALU_HIR;
        #1;
        chk("mfhi.data", hilo_out, 32'h1234_5678);
        chk("mfhi.nostall", {31'd0, stall_o}, 32'd0);
        alu_op = ALU_LOR;
        #1;
        chk("mflo.data", hilo_out, 32'h9ABC_DEF0);
        alu_op = ALU_ADD;
        #1;
        chk("hilo_out.other", hilo_out, 32'd0);
        tick();

        // MFHI issued during BUSY is held until the result lands
        op_valid_i = 1'b1; alu_op = ALU_MUL; signed_i = 1'b0;
        alusrc_1 = 32'h0001_0000; alusrc_2 = 32'h0003_0000;
        tick();
        alu_op = ALU_HIR;
        n = 1;
        while (n < 60) begin
            #1;
            if (stall_o !== 1'b1) break;
            n++;
            tick();
        end
        chk("mfhi_busy.stall_len", 32'(n), 32'd34);
        chk("mfhi_busy.data", hilo_out, ref_model(1'b0, 1'b0, 32'h0001_0000, 32'h0003_0000) >> 32);
        op_valid_i = 1'b0; alu_op = ALU_ADD;
        tick();

        // Flush at t+10 of DIVU
        mt(ALU_HIW, 32'hAAAA_5555, "mthi2");
        mt(ALU_LOW, 32'h5555_AAAA, "mtlo2");
        op_valid_i = 1'b1; alu_op = ALU_DIV; signed_i = 1'b0;
        alusrc_1 = 32'd1000; alusrc_2 = 32'd3;
        tick();
        op_valid_i = 1'b0; alu_op = ALU_ADD;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_busy.stall", {31'd0, stall_o}, 32'd0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_o === 1'b1) nd++;
            tick();
        end
        chk("flush_busy.nodone", 32'(nd), 32'd0);
        chk("flush_busy.hi", hi_o, 32'hAAAA_5555);
        chk("flush_busy.lo", lo_o, 32'h5555_AAAA);

        // Flush in the FIX cycle (t+33)
        op_valid_i = 1'b1; alu_op = ALU_MUL; signed_i = 1'b0;
        alusrc_1 = 32'd9; alusrc_2 = 32'd9;
        tick();
        op_valid_i = 1'b0; alu_op = ALU_ADD;
        repeat (32) tick();
        flush_i = 1'b1;
        #1;
        chk("flush_fix.done", {31'd0, done_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_fix.stall", {31'd0, stall_o}, 32'd0);
        chk("flush_fix.hi", hi_o, 32'hAAAA_5555);
        chk("flush_fix.lo", lo_o, 32'h5555_AAAA);

        // Flush while idle suppresses start and MTHI
        op_valid_i = 1'b1; alu_op = ALU_MUL; flush_i = 1'b1;
        #1;
        chk("flush_idle.start", {31'd0, stall_o}, 32'd0);
        tick();
        alu_op = ALU_HIW; alusrc_1 = 32'hDEAD_BEEF;
        #1;
        chk("flush_idle.nostall", {31'd0, stall_o}, 32'd0);
        tick();
        op_valid_i = 1'b0; alu_op = ALU_ADD; flush_i = 1'b0;
        #1;
        chk("flush_idle.hi", hi_o, 32'hAAAA_5555);

        // Reset at t+20 of MULT
        op_valid_i = 1'b1; alu_op = ALU_MUL; signed_i = 1'b1;
        alusrc_1 = 32'h0000_1234; alusrc_2 = 32'hFFFF_FFFB;
        tick();
        op_valid_i = 1'b0; alu_op = ALU_ADD;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.stall", {31'd0, stall_o}, 32'd0);
        chk("rst_mid.hi", hi_o, 32'd0);
        chk("rst_mid.lo", lo_o, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(ALU_MUL, 1'b0, 32'd6, 32'd7, 64'd42, "multu_6x7");

        // Randomized mul/div against the reference model
        for (int i = 0; i < 40; i++) begin
            isdiv = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(isdiv ? ALU_DIV : ALU_MUL, sgn, a, b, ref_model(isdiv, sgn, a, b), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
